adc_sample_scheduler: RTL and testbench
=======================================

Name: adc_sample_scheduler

Overview:
- Sequences the AD4008 serial reader. It issues conversion-start pulses at a programmable sample period and waits for the reader's new-data flag, with a timeout.
- It box-car averages 2^N consecutive samples and hands each averaged result downstream on a valid/ready interface.
- It sits between the register/config layer and the AD4008 reader. It is the only block allowed to start conversions.

Parameters:
- ADC_WIDTH, 16, width of reader sample and averaged output.
- PERIOD_WIDTH, 16, width of the period register.
- MIN_PERIOD, 40, smallest accepted sample period in clk cycles; smaller programmed values are clamped up.
- TIMEOUT_CYCLES, 255, cycles to wait in WAIT_DATA for adc_valid before abandoning the conversion.
- MAX_AVG_LOG2, 4, largest averaging exponent; the accumulator is ADC_WIDTH+MAX_AVG_LOG2 bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- enable  input  1  run request; level-sensitive.
- period  input  PERIOD_WIDTH  cycles between successive conv_start pulses.
- avg_log2  input  3  averaging exponent; values above MAX_AVG_LOG2 are clamped to MAX_AVG_LOG2.
- conv_start  output  1  one-cycle pulse telling the reader to start a conversion.
- adc_data  input  ADC_WIDTH  reader sample (unsigned), valid when adc_valid is high.
- adc_valid  input  1  reader new_data_flag, one-cycle pulse.
- out_data  output  ADC_WIDTH  averaged result.
- out_valid  output  1  out_data holds an untaken result.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky; set on any timeout; cleared only by reset.
- overrun_count  output  8  count of results dropped because the output was full; saturates at 255.

Behaviour:
- Reset (asynchronous, aresetn low): every output is 0, the FSM is in IDLE, and the accumulator, sample counter and period counter are cleared. Reset mid-conversion discards everything in flight.
- Period counter: reloads to 0 on each conv_start and increments every cycle, saturating. The period has "expired" when count >= effective_period-1, where effective_period = max(period, MIN_PERIOD). period is sampled every cycle, so a change takes effect at the next expiry check.
- IDLE: busy=0. When enable=1, go to TRIG on the next cycle.
- TRIG: conv_start=1 for exactly one cycle. If the sample counter is 0, latch the effective avg_log2 as window_log2. Then go to WAIT_DATA.
- WAIT_DATA: the timeout counter counts from 0.
  - When adc_valid=1: add adc_data, zero-extended, to the accumulator and increment the sample counter.
    - If the sample counter reaches 2^window_log2, the window is complete: result = accumulator >> window_log2 (floor). Then clear the accumulator and sample counter.
    - Go to PACE.
  - When the timeout counter reaches TIMEOUT_CYCLES-1 without adc_valid: set timeout_err, discard the sample (the accumulator is untouched), go to PACE.
- PACE: wait for period expiry.
  - If the period has already expired on entry, go to TRIG on the next cycle. Conversions never overlap; the effective rate slows instead.
  - On expiry: if enable=1 go to TRIG. If enable=0, clear the accumulator and sample counter (the partial window is lost) and go to IDLE.
- enable deassert during TRIG or WAIT_DATA: the current conversion completes or times out normally. The decision to stop is made in PACE.
- adc_valid outside WAIT_DATA: ignored.
- Output register:
  - A completed result loads out_data and sets out_valid in the cycle after the adc_valid that completed the window. Latency from adc_valid to out_valid is 1 cycle.
  - out_valid clears on a cycle where out_valid && out_ready, unless a new result loads in that same cycle. In that case out_valid stays 1 with the new data and no overrun is counted.
  - A completed result arriving while out_valid=1 && out_ready=0 is dropped: out_data is unchanged and overrun_count increments, saturating at 255.
- Arithmetic: the accumulator never overflows, since at most 2^MAX_AVG_LOG2 samples of ADC_WIDTH bits are summed. window_log2=0 means pass-through, one result per sample.

Test Plan:
- Pass-through: period=100, avg_log2=0, emulator data 0xAAAA, out_ready=1. Required: conv_start pulses exactly 100 cycles apart; each out_data=0xAAAA; out_valid one cycle after each adc_valid.
- Averaging: avg_log2=2, samples 0x0000, 0x0003, 0x0004, 0x0005. Required: single result 0x0003 (12>>2); no out_valid after the first three samples.
- Clamp and slow reader: period=10. Required: conv_start spacing >= 40. If the reader returns after 60 cycles, spacing = 60 + PACE/TRIG overhead (2 cycles), with no conv_start while in WAIT_DATA.
- Timeout: hold adc_valid low. Required: timeout_err=1 after 255 cycles in WAIT_DATA; next conv_start issued on period expiry; accumulator unchanged.
- Backpressure: out_ready=0, avg_log2=0, 5 samples. Required: out_data holds the first sample, overrun_count=4. Then pulse out_ready with a simultaneous completion. Required: new data loaded, count stays 4.
- Stop/reset: enable=0 mid-window. Required: busy falls after the next period expiry and the partial window is discarded. Then assert aresetn=0 mid-WAIT_DATA. Required: all outputs 0 immediately.

Source files
------------

// File: rtl/adc_sample_scheduler.sv
// Conversion scheduler for the AD4008 reader: paces conv_start pulses, waits
// for new data with a timeout, box-car averages 2^N samples and presents results.
module adc_sample_scheduler #(
  parameter int ADC_WIDTH      = 16,
  parameter int PERIOD_WIDTH   = 16,
  parameter int MIN_PERIOD     = 40,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_AVG_LOG2   = 4
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [2:0]              avg_log2,
  output logic                    conv_start,
  input  logic [ADC_WIDTH-1:0]    adc_data,
  input  logic                    adc_valid,
  output logic [ADC_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [7:0]              overrun_count
);

  localparam int ACC_W = ADC_WIDTH + MAX_AVG_LOG2;
  localparam int CNT_W = MAX_AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P   = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [2:0]              MAX_LOG = 3'(MAX_AVG_LOG2);
  localparam logic [TO_W-1:0]         TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_DATA, PACE} state_t;

  state_t                  state_reg, state_next;
  logic [PERIOD_WIDTH-1:0] period_cnt_reg;
  logic [TO_W-1:0]         timeout_cnt_reg;
  logic [ACC_W-1:0]        acc_reg;
  logic [CNT_W-1:0]        sample_cnt_reg;
  logic [2:0]              window_log2_reg;
  logic [ADC_WIDTH-1:0]    out_data_reg;
  logic                    out_valid_reg;
  logic                    timeout_err_reg;
  logic [7:0]              overrun_reg;

  logic [PERIOD_WIDTH-1:0] eff_period;
  logic [2:0]              eff_log2;
  logic                    expired;
  logic [ACC_W-1:0]        acc_sum;
  logic [CNT_W-1:0]        sample_inc;
  logic                    window_done;
  logic                    accept_sample;
  logic                    result_load;
  logic                    timeout_fire;
  logic                    clear_window;

  assign eff_period  = (period < MIN_P) ? MIN_P : period;
  assign eff_log2    = (avg_log2 > MAX_LOG) ? MAX_LOG : avg_log2;
  assign expired     = period_cnt_reg >= (eff_period - PERIOD_WIDTH'(1));
  assign acc_sum     = acc_reg + ACC_W'(adc_data);
  assign sample_inc  = sample_cnt_reg + CNT_W'(1);
  assign window_done = sample_inc == (CNT_W'(1) << window_log2_reg);

  always_comb begin
    state_next    = state_reg;
    conv_start    = 1'b0;
    accept_sample = 1'b0;
    result_load   = 1'b0;
    timeout_fire  = 1'b0;
    clear_window  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = TRIG;
      end
      TRIG: begin
        conv_start = 1'b1;
        state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (adc_valid) begin
          accept_sample = 1'b1;
          result_load   = window_done;
          state_next    = PACE;
        end else if (timeout_cnt_reg == TO_LAST) begin
          timeout_fire = 1'b1;
          state_next   = PACE;
        end
      end
      PACE: begin
        if (expired) begin
          if (enable) begin
            state_next = TRIG;
          end else begin
            clear_window = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // The conv_start cycle is count 0, so the register holds cycles elapsed since the pulse.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                   period_cnt_reg <= '0;
    else if (conv_start)            period_cnt_reg <= PERIOD_WIDTH'(1);
    else if (period_cnt_reg != '1)  period_cnt_reg <= period_cnt_reg + PERIOD_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                     timeout_cnt_reg <= '0;
    else if (state_reg != WAIT_DATA)  timeout_cnt_reg <= '0;
    else if (timeout_cnt_reg != '1)   timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
  end

  // Window size is frozen at the first conversion of each window.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      window_log2_reg <= '0;
      acc_reg         <= '0;
      sample_cnt_reg  <= '0;
    end else begin
      if (conv_start && sample_cnt_reg == '0) window_log2_reg <= eff_log2;
      if (clear_window || result_load) begin
        acc_reg        <= '0;
        sample_cnt_reg <= '0;
      end else if (accept_sample) begin
        acc_reg        <= acc_sum;
        sample_cnt_reg <= sample_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_data_reg    <= '0;
      out_valid_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      overrun_reg     <= '0;
    end else begin
      if (timeout_fire) timeout_err_reg <= 1'b1;
      if (result_load) begin
        if (!out_valid_reg || out_ready) begin
          out_data_reg  <= ADC_WIDTH'(acc_sum >> window_log2_reg);
          out_valid_reg <= 1'b1;
        end else if (overrun_reg != 8'hFF) begin
          overrun_reg <= overrun_reg + 8'd1;
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign busy          = state_reg != IDLE;
  assign out_data      = out_data_reg;
  assign out_valid     = out_valid_reg;
  assign timeout_err   = timeout_err_reg;
  assign overrun_count = overrun_reg;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a simple AD4008 reader emulator
// that answers each conv_start after a programmable latency.
module tb_adc_sample_scheduler;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd100;
  logic [2:0]  avg_log2 = 3'd0;
  logic        conv_start;
  logic [15:0] adc_data = 16'h0;
  logic        adc_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  overrun_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          emu_lat = 5;
  bit          emu_on = 1'b1;
  logic [15:0] emu_fill = 16'hAAAA;
  logic [15:0] emu_q[$];
  int          emu_wait = 0;

  adc_sample_scheduler dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .period(period),
    .avg_log2(avg_log2), .conv_start(conv_start), .adc_data(adc_data),
    .adc_valid(adc_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reader emulator: adc_valid is high for one cycle, emu_lat cycles after conv_start.
  always @(negedge clk) begin
    adc_valid = 1'b0;
    if (!aresetn) begin
      emu_wait = 0;
    end else begin
      if (emu_wait > 0) begin
        emu_wait--;
        if (emu_wait == 0) begin
          adc_valid = 1'b1;
          adc_data = (emu_q.size() > 0) ? emu_q.pop_front() : emu_fill;
        end
      end
      if (conv_start && emu_on) emu_wait = emu_lat;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_conv(output int at);
    at = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (conv_start === 1'b1) begin
        at = cyc;
        break;
      end
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL wait_conv: no conv_start within 1000 cycles (got none, need one)");
    end else begin
      $display("conv_start at cycle %0d", at);
    end
  endtask

  task automatic do_reset(input logic [15:0] per, input logic [2:0] lg, input int lat);
    aresetn = 1'b0;
    enable = 1'b0;
    emu_q.delete();
    step(2);
    period = per;
    avg_log2 = lg;
    emu_lat = lat;
    emu_on = 1'b1;
    out_ready = 1'b1;
    aresetn = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    do_reset(16'd100, 3'd0, 5);
    total++;
    if ({busy, conv_start, out_valid, timeout_err} !== 4'b0000 || out_data !== 16'h0 ||
        overrun_count !== 8'h0) begin
      bad++;
      $display("FAIL reset_state: busy=%b conv=%b ov=%b te=%b od=%h oc=%0d, need all zero",
               busy, conv_start, out_valid, timeout_err, out_data, overrun_count);
    end
  endtask

  task automatic test_pass_through;
    int c0, c1;
    do_reset(16'd100, 3'd0, 5);
    emu_fill = 16'hAAAA;
    enable = 1'b1;
    wait_conv(c0);
    for (int i = 0; i < 3; i++) begin
      step(5);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL pt_early_valid[%0d]: out_valid=%b need 0", i, out_valid);
      end
      step(1);
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'hAAAA) begin
        bad++; $display("FAIL pt_result[%0d]: ov=%b od=%h need 1/aaaa", i, out_valid, out_data);
      end
      step(1);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL pt_taken[%0d]: out_valid=%b need 0", i, out_valid);
      end
      wait_conv(c1);
      total++;
      if (c1 - c0 !== 100) begin
        bad++; $display("FAIL pt_spacing[%0d]: got %0d need 100", i, c1 - c0);
      end
      c0 = c1;
    end
  endtask

  task automatic test_averaging;
    int c;
    do_reset(16'd40, 3'd2, 5);
    emu_q = '{16'h0000, 16'h0003, 16'h0004, 16'h0005};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_conv(c);
      step(6);
      total++;
      if (out_valid !== (i == 3)) begin
        bad++; $display("FAIL avg_valid[%0d]: out_valid=%b need %0d", i, out_valid, i == 3);
      end
    end
    total++;
    if (out_data !== 16'h0003) begin
      bad++; $display("FAIL avg_result: out_data=%h need 0003", out_data);
    end
  endtask

  task automatic test_clamp_slow;
    int c0, c1, c2, c3;
    do_reset(16'd10, 3'd0, 5);
    enable = 1'b1;
    wait_conv(c0);
    wait_conv(c1);
    total++;
    if (c1 - c0 !== 40) begin
      bad++; $display("FAIL clamp_spacing: got %0d need 40", c1 - c0);
    end
    step(1);
    emu_lat = 60;
    wait_conv(c2);
    wait_conv(c3);
    total++;
    if (c3 - c2 !== 62) begin
      bad++; $display("FAIL slow_spacing: got %0d need 62", c3 - c2);
    end
  endtask

  task automatic test_timeout;
    int c0, c1, c2;
    do_reset(16'd300, 3'd1, 5);
    emu_q = '{16'h0010};
    enable = 1'b1;
    wait_conv(c0);
    step(1);
    emu_on = 1'b0;
    step(5);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL to_half_window: out_valid=%b need 0", out_valid);
    end
    wait_conv(c1);
    total++;
    if (c1 - c0 !== 300) begin
      bad++; $display("FAIL to_spacing1: got %0d need 300", c1 - c0);
    end
    step(255);
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL to_early: timeout_err=%b need 0", timeout_err);
    end
    step(1);
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL to_flag: te=%b busy=%b need 1/1", timeout_err, busy);
    end
    emu_on = 1'b1;
    emu_q = '{16'h0020};
    wait_conv(c2);
    total++;
    if (c2 - c1 !== 300) begin
      bad++; $display("FAIL to_spacing2: got %0d need 300", c2 - c1);
    end
    step(6);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h0018 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL to_acc_kept: ov=%b od=%h te=%b need 1/0018/1",
                      out_valid, out_data, timeout_err);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    do_reset(16'd40, 3'd0, 5);
    out_ready = 1'b0;
    emu_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_conv(c);
      step(6);
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h0001 || overrun_count !== 8'd4) begin
      bad++; $display("FAIL bp_hold: ov=%b od=%h oc=%0d need 1/0001/4",
                      out_valid, out_data, overrun_count);
    end
    wait_conv(c);
    step(5);
    out_ready = 1'b1;
    step(1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h0006 || overrun_count !== 8'd4) begin
      bad++; $display("FAIL bp_swap: ov=%b od=%h oc=%0d need 1/0006/4",
                      out_valid, out_data, overrun_count);
    end
    step(1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_stop_reset;
    int c0, c1, c;
    do_reset(16'd50, 3'd2, 5);
    emu_fill = 16'h0100;
    enable = 1'b1;
    wait_conv(c0);
    wait_conv(c1);
    step(6);
    enable = 1'b0;
    step(43);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL stop_before_expiry: busy=%b need 1", busy);
    end
    step(1);
    total++;
    if (busy !== 1'b0 || conv_start !== 1'b0) begin
      bad++; $display("FAIL stop_idle: busy=%b conv=%b need 0/0", busy, conv_start);
    end
    emu_q = '{16'h0004, 16'h0004, 16'h0004, 16'h0008};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b0;
      wait_conv(c);
      step(6);
      total++;
      if (out_valid !== (i == 3)) begin
        bad++; $display("FAIL stop_window[%0d]: out_valid=%b need %0d", i, out_valid, i == 3);
      end
    end
    total++;
    if (out_data !== 16'h0005) begin
      bad++; $display("FAIL stop_fresh_avg: out_data=%h need 0005", out_data);
    end
    wait_conv(c);
    step(3);
    aresetn = 1'b0;
    #1;
    total++;
    if ({busy, conv_start, out_valid, timeout_err} !== 4'b0000 || out_data !== 16'h0 ||
        overrun_count !== 8'h0) begin
      bad++; $display("FAIL async_reset: busy=%b conv=%b ov=%b te=%b od=%h oc=%0d need zeros",
                      busy, conv_start, out_valid, timeout_err, out_data, overrun_count);
    end
    enable = 1'b0;
    step(2);
    aresetn = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_averaging();
    test_clamp_slow();
    test_timeout();
    test_back_to_back();
    test_stop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
